// File: rtl/nios2_pio_pkg.sv
// Shared constants for the Nios II parallel I/O peripheral: register offsets
// and edge-capture selector encodings.
package nios2_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA      = 3'd0;
  localparam logic [2:0] PIO_ADDR_DIRECTION = 3'd1;
  localparam logic [2:0] PIO_ADDR_IRQMASK   = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGECAP   = 3'd3;
  localparam logic [2:0] PIO_ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLEAR  = 3'd5;

  localparam int unsigned PIO_EDGE_RISE = 0;
  localparam int unsigned PIO_EDGE_FALL = 1;
  localparam int unsigned PIO_EDGE_ANY  = 2;

endpackage

// File: rtl/nios2_pio_sync.sv
// Input synchroniser chain plus one history flop; produces the synchronised
// pin value and a per-bit edge pulse of the selected polarity.
module nios2_pio_sync
  import nios2_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = PIO_EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples its predecessor's value from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= pio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  // NOTE: the default assignment first keeps this block purely combinational.
  always_comb begin
    edge_pulse = in_sync & ~in_prev;
    if (EDGE_TYPE == PIO_EDGE_FALL)     edge_pulse = ~in_sync & in_prev;
    else if (EDGE_TYPE == PIO_EDGE_ANY) edge_pulse = in_sync ^ in_prev;
  end

endmodule

// File: rtl/nios2_pio_gen.sv
// Parametrised bidirectional PIO on the Avalon-MM bus: register file, read
// mux with one-cycle latency, edge capture and maskable level interrupt.
module nios2_pio_gen
  import nios2_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 11,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int unsigned      EDGE_TYPE   = PIO_EDGE_RISE,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out, dir, irqmask, edgecap;
  logic [WIDTH-1:0] in_sync, edge_pulse, wdata, ec_clear;
  logic [31:0]      rd_word;
  logic             wr_en, rd_en;
  logic             unused_writedata;

  assign wr_en    = chipselect && !write_n;
  assign rd_en    = chipselect && !read_n;
  assign wdata    = writedata[WIDTH-1:0];
  assign ec_clear = (wr_en && address == PIO_ADDR_EDGECAP) ? wdata : '0;
  // Bits of writedata above WIDTH are deliberately ignored.
  assign unused_writedata = ^{1'b0, writedata};

  nios2_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .pio_in    (pio_in),
    .in_sync   (in_sync),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    rd_word = '0;
    case (address)
      PIO_ADDR_DATA:      rd_word[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      PIO_ADDR_DIRECTION: rd_word[WIDTH-1:0] = dir;
      PIO_ADDR_IRQMASK:   rd_word[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP:   rd_word[WIDTH-1:0] = edgecap;
      default:            rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
      dir      <= RESET_DIR;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      irq     <= |(edgecap & irqmask);
      // A fresh edge overrides a simultaneous write-1-to-clear.
      edgecap <= (edgecap & ~ec_clear) | edge_pulse;
      if (rd_en) readdata <= rd_word;
      if (wr_en) begin
        case (address)
          PIO_ADDR_DATA:      data_out <= wdata;
          PIO_ADDR_DIRECTION: dir      <= wdata;
          PIO_ADDR_IRQMASK:   irqmask  <= wdata;
          PIO_ADDR_OUTSET:    data_out <= data_out | wdata;
          PIO_ADDR_OUTCLEAR:  data_out <= data_out & ~wdata;
          default: ;
        endcase
      end
    end
  end

  assign out_port = data_out;
  assign oe       = dir;

endmodule

// File: tb/tb_nios2_pio_gen.sv
// Scoreboard bench for nios2_pio_gen: three instances (11, 32 and 4 bits)
// share one bus; a register-level model predicts every read and output.
module tb_nios2_pio_gen;

  localparam int SYNC = 2;
  localparam logic [31:0] M_MASK [3] = '{32'h0000_07FF, 32'hFFFF_FFFF, 32'h0000_000F};
  localparam logic [31:0] M_RV   [3] = '{32'h0000_05A5, 32'h0, 32'h0};
  localparam logic [31:0] M_RD   [3] = '{32'h0000_07FF, 32'hFFFF_FFFF, 32'h0000_000F};
  localparam logic [31:0] EXP_RST [8] = '{32'h5A5, 32'h7FF, 0, 0, 0, 0, 0, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0, write_n = 1'b1, read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [10:0] pio_in = '0;
  logic [31:0] pin32 = '0;
  logic [3:0]  pin4 = '0;
  logic [31:0] readdata, rd32, rd4;
  logic [10:0] out_port, oe;
  logic [31:0] out32, oe32;
  logic [3:0]  out4, oe4;
  logic        irq, irq32, irq4;

  always #5 clk = ~clk;

  nios2_pio_gen #(.WIDTH(11), .RESET_VALUE(11'h5A5), .RESET_DIR(11'h7FF),
                  .EDGE_TYPE(0), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .pio_in(pio_in), .out_port(out_port), .oe(oe), .irq(irq));

  nios2_pio_gen #(.WIDTH(32), .RESET_VALUE(32'h0), .RESET_DIR(32'hFFFF_FFFF),
                  .EDGE_TYPE(0), .SYNC_STAGES(SYNC)) u_w32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd32),
    .pio_in(pin32), .out_port(out32), .oe(oe32), .irq(irq32));

  nios2_pio_gen #(.WIDTH(4), .RESET_VALUE(4'h0), .RESET_DIR(4'hF),
                  .EDGE_TYPE(0), .SYNC_STAGES(SYNC)) u_w4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd4),
    .pio_in(pin4), .out_port(out4), .oe(oe4), .irq(irq4));

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rd_of(input int i);
    return (i == 0) ? readdata : (i == 1) ? rd32 : rd4;
  endfunction
  function automatic logic [31:0] out_of(input int i);
    return (i == 0) ? 32'(out_port) : (i == 1) ? out32 : 32'(out4);
  endfunction
  function automatic logic [31:0] oe_of(input int i);
    return (i == 0) ? 32'(oe) : (i == 1) ? oe32 : 32'(oe4);
  endfunction
  function automatic logic irq_of(input int i);
    return (i == 0) ? irq : (i == 1) ? irq32 : irq4;
  endfunction

  // Reference model: register contents after each clock edge; pins are seen
  // through a SYNC-deep delay line, edges come from two adjacent taps.
  typedef struct packed {
    logic [2:0]       addr;
    logic [2:0][31:0] val;
  } rd_exp_t;

  rd_exp_t     sb [$];
  logic [31:0] m_data [3], m_dir [3], m_mk [3], m_ec [3];
  logic        m_irq [3];
  logic [31:0] m_hist [3][SYNC+1];
  logic [31:0] m_pins [3];
  logic [31:0] m_ins, m_edg, m_wd;
  rd_exp_t     m_e;
  logic        m_wr, m_rd;

  always @(posedge clk) begin
    m_wr = chipselect && !write_n;
    m_rd = chipselect && !read_n;
    m_pins[0] = 32'(pio_in);
    m_pins[1] = pin32;
    m_pins[2] = 32'(pin4);
    m_e = '0;
    m_e.addr = address;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_data[i] = M_RV[i];
        m_dir[i]  = M_RD[i];
        m_mk[i]   = '0;
        m_ec[i]   = '0;
        m_irq[i]  = 1'b0;
        for (int s = 0; s <= SYNC; s++) m_hist[i][s] = '0;
      end else begin
        m_ins = m_hist[i][SYNC-1];
        m_edg = m_ins & ~m_hist[i][SYNC];
        m_wd  = writedata & M_MASK[i];
        m_irq[i] = |(m_ec[i] & m_mk[i]);
        if (m_rd) begin
          case (address)
            3'd0: m_e.val[i] = (m_dir[i] & m_data[i]) | (~m_dir[i] & m_ins);
            3'd1: m_e.val[i] = m_dir[i];
            3'd2: m_e.val[i] = m_mk[i];
            3'd3: m_e.val[i] = m_ec[i];
            default: m_e.val[i] = '0;
          endcase
        end
        m_ec[i] = (m_ec[i] & ~((m_wr && address == 3'd3) ? m_wd : 32'h0)) | m_edg;
        if (m_wr) begin
          case (address)
            3'd0: m_data[i] = m_wd;
            3'd1: m_dir[i]  = m_wd;
            3'd2: m_mk[i]   = m_wd;
            3'd4: m_data[i] = m_data[i] | m_wd;
            3'd5: m_data[i] = m_data[i] & ~m_wd;
            default: ;
          endcase
        end
        for (int s = SYNC; s > 0; s--) m_hist[i][s] = m_hist[i][s-1];
        m_hist[i][0] = m_pins[i];
      end
    end
    if (m_rd && !reset) sb.push_back(m_e);
  end

  // Monitor: readdata is presented the cycle after a read and held otherwise.
  logic             rd_q = 1'b0, rst_q = 1'b0, mon_en = 1'b0;
  logic [2:0][31:0] hold = '0;
  rd_exp_t          mon_e;

  always @(posedge clk) begin
    rd_q  <= chipselect && !read_n && !reset;
    rst_q <= reset;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) hold = '0;
      if (rd_q) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got empty queue, expected a pending read (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          for (int i = 0; i < 3; i++)
            check($sformatf("rd%0d_addr%0d", i, mon_e.addr), rd_of(i), mon_e.val[i]);
          hold = mon_e.val;
        end
      end else begin
        for (int i = 0; i < 3; i++) check($sformatf("rd%0d_hold", i), rd_of(i), hold[i]);
      end
      for (int i = 0; i < 3; i++) begin
        check($sformatf("out_port%0d", i), out_of(i), m_data[i]);
        check($sformatf("oe%0d", i), oe_of(i), m_dir[i]);
        check($sformatf("irq%0d", i), 32'(irq_of(i)), 32'(m_irq[i]));
      end
    end
  end

  // Bus access lasting one cycle; called just after a falling edge.
  task automatic bus(input bit is_wr, input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    address    = a;
    writedata  = d;
    write_n    = !is_wr;
    read_n     = is_wr;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      bus(1'b0, 3'(a), 32'h0);
      check($sformatf("rst_read_a%0d", a), readdata, EXP_RST[a]);
    end
    check("rst_out_port", 32'(out_port), 32'h5A5);
    check("rst_irq", 32'(irq), 32'h0);

    // Reset during a write: the write is dropped.
    reset = 1'b1;
    bus(1'b1, 3'd0, 32'h123);
    reset = 1'b0;
    check("rst_abort", 32'(out_port), 32'h5A5);

    bus(1'b1, 3'd0, 32'h0F0); check("set_data", 32'(out_port), 32'h0F0);
    bus(1'b1, 3'd4, 32'h003); check("outset",   32'(out_port), 32'h0F3);
    bus(1'b1, 3'd5, 32'h030); check("outclear", 32'(out_port), 32'h0C3);
    bus(1'b0, 3'd4, 32'h0);   check("rd_outset",   readdata, 32'h0);
    bus(1'b0, 3'd5, 32'h0);   check("rd_outclear", readdata, 32'h0);

    bus(1'b1, 3'd1, 32'h00F);
    bus(1'b1, 3'd0, 32'h7FF);
    pio_in = 11'h550;
    idle(3);
    bus(1'b0, 3'd0, 32'h0);
    check("mixed_data", readdata, 32'h55F);
    check("mixed_oe", 32'(oe), 32'h00F);

    bus(1'b1, 3'd1, 32'h0);
    pio_in = 11'h000;
    idle(4);
    bus(1'b1, 3'd3, 32'h7FF);
    bus(1'b1, 3'd2, 32'h001);
    idle(2);
    check("irq_idle", 32'(irq), 32'h0);
    pio_in[0] = 1'b1;
    idle(3); check("irq_before", 32'(irq), 32'h0);
    idle(1); check("irq_set", 32'(irq), 32'h1);
    bus(1'b1, 3'd3, 32'h001); check("irq_hold_clr", 32'(irq), 32'h1);
    idle(1); check("irq_drop", 32'(irq), 32'h0);
    pio_in[0] = 1'b0;
    idle(5);
    bus(1'b0, 3'd3, 32'h0);
    check("fall_no_cap", readdata, 32'h0);
    check("fall_no_irq", 32'(irq), 32'h0);

    // Rising edge on bit 2 is detected in the same cycle as its clear.
    pio_in[2] = 1'b1;
    idle(2);
    bus(1'b1, 3'd3, 32'h004);
    bus(1'b0, 3'd3, 32'h0);
    check("collide", readdata, 32'h004);

    bus(1'b1, 3'd1, 32'hFFFF_FFFF);
    bus(1'b1, 3'd0, 32'hFFFF_FFFF);
    bus(1'b1, 3'd7, 32'h0);
    bus(1'b0, 3'd0, 32'h0);
    check("w32_data", rd32, 32'hFFFF_FFFF);
    check("w4_data",  rd4,  32'h0000_000F);
    check("w11_data", readdata, 32'h0000_07FF);
    bus(1'b0, 3'd7, 32'h0);
    check("w32_a7", rd32, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) pio_in = 11'($urandom);
      if (op == 0 && $urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end else if (op < 3) idle(1);
      else if (op < 6) bus(1'b0, 3'($urandom_range(0, 7)), 32'h0);
      else bus(1'b1, 3'($urandom_range(0, 7)), $urandom);
    end

    idle(3);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
